// File: rtl/lsu_pkg.sv
// Shared encodings for the block-RAM load/store unit: access sizes, FSM states
// and the alignment check used at request accept.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_RESP
    } lsu_state_t;

    // Reserved size is folded in here so the FSM sees a single reject term.
    function automatic logic align_err(input size_t size, input logic [1:0] lo2);
        case (size)
            SZ_BYTE: align_err = 1'b0;
            SZ_HALF: align_err = lo2[0];
            SZ_WORD: align_err = |lo2;
            default: align_err = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: extracts and extends load data from a RAM word and merges
// sub-word store data into the old word for read-modify-write.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  size_t       size,
    input  logic        is_signed,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[{lane, 3'b000} +: 8];
        half_v = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: load_data = {{24{is_signed & byte_v[7]}}, byte_v};
            SZ_HALF: load_data = {{16{is_signed & half_v[15]}}, half_v};
            default: load_data = word;
        endcase
    end

    always_comb begin
        store_word = word;
        case (size)
            SZ_BYTE: store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = word;
        endcase
    end

endmodule

// File: rtl/bram_lsu.sv
// Load/store initiator for a single-port 32-bit block RAM with one-cycle
// registered reads; sub-word stores are done as read-modify-write.
module bram_lsu
    import lsu_pkg::*;
#(
    parameter int ADR_WIDTH   = 11,
    parameter int CHECK_RANGE = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [15:0] mem_a,
    output logic        mem_we,
    output logic [31:0] mem_do,
    input  logic [31:0] mem_di
);

    // state | meaning
    // IDLE  | ready for a request
    // RD    | RAM samples mem_a at the end of this cycle
    // CAP   | mem_di holds the old word; extract load or merge store
    // WR    | mem_we high for this one cycle
    // RESP  | resp_valid pulse

    lsu_state_t  state_q, state_d;
    logic [1:0]  lane_q, lane_d;
    size_t       size_q, size_d;
    logic        signed_q, signed_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mem_a_q, mem_a_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_do_q, mem_do_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        req_ready_q, req_ready_d;

    size_t       req_size_e;
    logic        range_err;
    logic        req_err;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_size_e = size_t'(req_size);
    assign range_err  = (CHECK_RANGE != 0) && ((req_addr >> ADR_WIDTH) != 16'd0);
    assign req_err    = align_err(req_size_e, req_addr[1:0]) || range_err;

    lsu_lane u_lane (
        .word       (mem_di),
        .lane       (lane_q),
        .size       (size_q),
        .is_signed  (signed_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        size_d       = size_q;
        signed_d     = signed_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        mem_a_d      = mem_a_q;
        mem_do_d     = mem_do_q;
        resp_rdata_d = resp_rdata_q;
        mem_we_d     = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        req_ready_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    lane_d      = req_addr[1:0];
                    size_d      = req_size_e;
                    signed_d    = req_signed;
                    we_d        = req_we;
                    wdata_d     = req_wdata[15:0];
                    mem_a_d     = {req_addr[15:2], 2'b00};
                    if (req_err) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && (req_size_e == SZ_WORD)) begin
                        state_d  = ST_WR;
                        mem_we_d = 1'b1;
                        mem_do_d = req_wdata;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: state_d = ST_CAP;
            ST_CAP: begin
                if (we_q) begin
                    state_d  = ST_WR;
                    mem_we_d = 1'b1;
                    mem_do_d = store_word;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            ST_WR: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= ST_IDLE;
            lane_q       <= 2'b00;
            size_q       <= SZ_BYTE;
            signed_q     <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= 16'd0;
            mem_a_q      <= 16'd0;
            mem_we_q     <= 1'b0;
            mem_do_q     <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            req_ready_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            mem_a_q      <= mem_a_d;
            mem_we_q     <= mem_we_d;
            mem_do_q     <= mem_do_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_a      = mem_a_q;
    assign mem_we     = mem_we_q;
    assign mem_do     = mem_do_q;

endmodule

// File: tb/tb_bram_lsu.sv
// Bench for bram_lsu: two instances (range checking on/off), each with its own
// RAM, checked against an arithmetic reference model of memory and responses.
module tb_bram_lsu;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        req_vld [2];
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [15:0] req_addr = 16'd0;
    logic [31:0] req_wdata = 32'd0;

    logic        rdy [2];
    logic        rv [2];
    logic        re [2];
    logic        mwe [2];
    logic [31:0] rdata [2];
    logic [31:0] mdo [2];
    logic [31:0] mdi [2];
    logic [15:0] ma [2];

    logic [31:0] ram [2][512];
    logic [31:0] ref_mem [2][512];
    logic [31:0] last_rdata [2];

    int n_checks = 0;
    int n_pass = 0;

    always #5 sys_clk = ~sys_clk;

    bram_lsu #(.ADR_WIDTH(11), .CHECK_RANGE(1)) u_dut1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_vld[1]), .req_ready(rdy[1]), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[1]), .resp_err(re[1]), .resp_rdata(rdata[1]),
        .mem_a(ma[1]), .mem_we(mwe[1]), .mem_do(mdo[1]), .mem_di(mdi[1])
    );

    bram_lsu #(.ADR_WIDTH(11), .CHECK_RANGE(0)) u_dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_vld[0]), .req_ready(rdy[0]), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv[0]), .resp_err(re[0]), .resp_rdata(rdata[0]),
        .mem_a(ma[0]), .mem_we(mwe[0]), .mem_do(mdo[0]), .mem_di(mdi[0])
    );

    // Single-port RAMs decoding byte-address bits [10:2], one-cycle read.
    always @(posedge sys_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mwe[i]) ram[i][ma[i][10:2]] <= mdo[i];
            mdi[i] <= ram[i][ma[i][10:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sgn, input logic [1:0] a);
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = (w >> (8 * a)) & 32'hFF;
                if (sgn && v >= 32'h80) v = v - 32'h100;
            end
            2'd1: begin
                v = (w >> (16 * a[1])) & 32'hFFFF;
                if (sgn && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] sz,
                                                input logic [1:0] a, input logic [31:0] wd);
        logic [31:0] m;
        case (sz)
            2'd0: begin
                m = 32'hFF << (8 * a);
                return (w & ~m) | ((wd & 32'hFF) << (8 * a));
            end
            2'd1: begin
                m = 32'hFFFF << (16 * a[1]);
                return (w & ~m) | ((wd & 32'hFFFF) << (16 * a[1]));
            end
            default: return wd;
        endcase
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [15:0] addr, input int chk);
        return (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) ||
               (sz == 2'd2 && addr % 4 != 0) || (chk != 0 && addr >= 16'd2048);
    endfunction

    // Issue one request on instance sel, starting and ending just after a falling edge.
    task automatic do_op(input int sel, input logic we, input logic [1:0] sz, input logic sgn,
                         input logic [15:0] addr, input logic [31:0] wd);
        logic [15:0] exp_a;
        logic [8:0]  idx;
        logic        e_err;
        int          e_lat, e_nwe, lat, wen;
        logic [31:0] nw, do_seen, got_err;
        logic        got, astable;
        exp_a = addr & 16'hFFFC;
        idx   = addr[10:2];
        e_err = model_err(sz, addr, sel);
        nw    = 32'd0;
        if (e_err) begin
            e_lat = 1; e_nwe = 0;
        end else if (we) begin
            nw = model_store(ref_mem[sel][idx], sz, addr[1:0], wd);
            ref_mem[sel][idx] = nw;
            e_nwe = 1;
            e_lat = (sz == 2'd2) ? 2 : 4;
        end else begin
            e_nwe = 0; e_lat = 3;
            last_rdata[sel] = model_load(ref_mem[sel][idx], sz, sgn, addr[1:0]);
        end

        req_we = we; req_size = sz; req_signed = sgn; req_addr = addr; req_wdata = wd;
        req_vld[sel] = 1'b1;
        check("ready_before", 32'(rdy[sel]), 32'd1);
        @(negedge sys_clk);
        req_vld[sel] = 1'b0;
        got = 1'b0; astable = 1'b1; lat = 0; wen = 0; do_seen = 32'd0; got_err = 32'd0;
        for (int k = 1; k <= 8 && !got; k++) begin
            if (k > 1) @(negedge sys_clk);
            if (ma[sel] !== exp_a) astable = 1'b0;
            if (mwe[sel]) begin wen++; do_seen = mdo[sel]; end
            if (rv[sel]) begin got = 1'b1; lat = k; got_err = 32'(re[sel]); end
        end
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_err", got_err, 32'(e_err));
        check("resp_rdata", rdata[sel], last_rdata[sel]);
        check("mem_we_cycles", 32'(wen), 32'(e_nwe));
        check("mem_a_stable", 32'(astable), 32'd1);
        if (e_nwe != 0) check("mem_do", do_seen, nw);
        @(negedge sys_clk);
        check("resp_pulse_end", 32'(rv[sel]), 32'd0);
        check("ready_after", 32'(rdy[sel]), 32'd1);
    endtask

    initial begin
        logic [5:0]  rdy_seen, we_seen, rv_seen;
        logic [15:0] a;
        logic [1:0]  sz;
        int          sel, mism;

        req_vld[0] = 1'b0; req_vld[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            last_rdata[i] = 32'd0;
            for (int w = 0; w < 512; w++) begin
                ram[i][w] = (w == 0) ? 32'h8899AABB : $urandom;
                ref_mem[i][w] = ram[i][w];
            end
        end

        repeat (2) @(negedge sys_clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ready", 32'(rdy[i]), 32'd1);
            check("rst_mem_a", 32'(ma[i]), 32'd0);
            check("rst_mem_we", 32'(mwe[i]), 32'd0);
            check("rst_mem_do", mdo[i], 32'd0);
            check("rst_resp_valid", 32'(rv[i]), 32'd0);
            check("rst_resp_err", 32'(re[i]), 32'd0);
            check("rst_resp_rdata", rdata[i], 32'd0);
        end
        sys_rst = 1'b0;
        @(negedge sys_clk);

        do_op(1, 1'b0, 2'd2, 1'b0, 16'h0000, 32'd0);
        check("tp1_word_load", rdata[1], 32'h8899AABB);
        do_op(1, 1'b0, 2'd0, 1'b1, 16'h0001, 32'd0);
        check("tp2_byte_signed", rdata[1], 32'hFFFFFFAA);
        do_op(1, 1'b0, 2'd0, 1'b0, 16'h0001, 32'd0);
        check("tp2_byte_unsigned", rdata[1], 32'h000000AA);
        do_op(1, 1'b0, 2'd1, 1'b1, 16'h0002, 32'd0);
        check("tp2_half_signed", rdata[1], 32'hFFFF8899);
        do_op(1, 1'b1, 2'd1, 1'b0, 16'h0002, 32'h00001234);
        do_op(1, 1'b0, 2'd2, 1'b0, 16'h0000, 32'd0);
        check("tp3_after_half_store", rdata[1], 32'h1234AABB);
        do_op(1, 1'b1, 2'd2, 1'b0, 16'h0003, 32'hDEADBEEF);
        do_op(1, 1'b0, 2'd1, 1'b0, 16'h0001, 32'd0);
        do_op(1, 1'b1, 2'd3, 1'b0, 16'h0004, 32'h01020304);
        do_op(1, 1'b0, 2'd2, 1'b0, 16'h0800, 32'd0);
        do_op(0, 1'b0, 2'd2, 1'b0, 16'h0800, 32'd0);
        check("tp5_alias_word0", rdata[0], 32'h8899AABB);

        // Reset lands in CAP of a byte store while req_valid stays high.
        req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 16'h0005; req_wdata = 32'h0000005A;
        req_vld[1] = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("abort_mem_we", 32'(mwe[1]), 32'd0);
        check("abort_resp_valid", 32'(rv[1]), 32'd0);
        check("abort_ram_word", ram[1][1], ref_mem[1][1]);
        last_rdata[0] = 32'd0; last_rdata[1] = 32'd0;
        sys_rst = 1'b0;
        check("abort_ready", 32'(rdy[1]), 32'd1);
        ref_mem[1][1] = model_store(ref_mem[1][1], 2'd0, 2'd1, 32'h0000005A);
        rdy_seen = '0; we_seen = '0; rv_seen = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk);
            rdy_seen[k] = rdy[1]; we_seen[k] = mwe[1]; rv_seen[k] = rv[1];
        end
        req_vld[1] = 1'b0;
        check("held_ready_pattern", 32'(rdy_seen), 32'b010000);
        check("held_we_pattern", 32'(we_seen), 32'b000100);
        check("held_rv_pattern", 32'(rv_seen), 32'b001000);
        repeat (4) @(negedge sys_clk);
        check("held_second_done", 32'(rdy[1]), 32'd1);
        check("held_rdata_reset", rdata[1], 32'd0);

        for (int n = 0; n < 150; n++) begin
            sel = int'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = 16'($urandom);
            else a = 16'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd2) a = a & 16'hFFFC;
                else if (sz == 2'd1) a = a & 16'hFFFE;
            end
            do_op(sel, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
        end

        mism = 0;
        for (int i = 0; i < 2; i++)
            for (int w = 0; w < 512; w++)
                if (ram[i][w] !== ref_mem[i][w]) mism++;
        check("ram_final", 32'(mism), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
